voice_scheduler: RTL and testbench
==================================

# voice_scheduler

Allocates incoming note-on/note-off key events across NUM_VOICES parallel sample-playback voices, each driven by its own per-voice increment controller. It sits between the key-event source and the voice bank. It chooses a free voice, or retriggers/steals one, issues start/stop pulses, and tracks per-voice busy state and age.

## Interface
- NUM_VOICES, 4, number of voices; power of two, 2..16
- KEY_W, 7, key code width
- AGE_W, 8, per-voice age counter width
- Clk  in  1  system clock, all logic on rising edge
- Reset_n  in  1  asynchronous, active-low reset; one clock domain, single reset
- init  in  1  level; scheduler leaves IDLE once seen high
- sample_clk  in  1  sample-rate clock, sampled as data in Clk domain
- key_valid  in  1  key event present
- key_ready  out  1  scheduler can accept an event
- key_on  in  1  1 = note-on, 0 = note-off
- key_code  in  KEY_W  key number
- voice_done  in  NUM_VOICES  per-voice one-cycle pulse, note finished
- voice_start  out  NUM_VOICES  one-hot one-cycle start pulse (new_note to voice)
- voice_stop  out  NUM_VOICES  one-hot one-cycle stop pulse
- voice_key  out  NUM_VOICES*KEY_W  key assigned to each voice; voice i at bits [i*KEY_W +: KEY_W]
- voice_busy  out  NUM_VOICES  voice currently owned
- steal  out  1  one-cycle pulse, asserted with a voice_start that preempted a busy voice
- active_count  out  $clog2(NUM_VOICES)+1  popcount of voice_busy

## Operation
- FSM states: IDLE, READY, SEARCH, ISSUE.
  - IDLE -> READY when init = 1.
  - READY -> SEARCH on key_valid && key_ready.
  - SEARCH -> ISSUE always.
  - ISSUE -> READY always.
- key_ready = 1 only in READY.
- Event is latched on acceptance: key_on, key_code.
- SEARCH computes target voice from registered voice_busy, voice_key and ages. Selection is registered.
- Note-on priority:
  1. Busy voice whose voice_key equals key_code (retrigger), lowest index.
  2. Lowest-index non-busy voice.
  3. Steal: busy voice with maximum age, ties to lowest index. steal = 1.
- Note-on ISSUE: voice_start[v] = 1. At ISSUE's closing edge: voice_busy[v] <= 1, voice_key[v] <= key_code, age[v] <= 0. Retrigger is not a steal (steal = 0).
- Note-off: target is the lowest-index busy voice with matching key.
  - ISSUE asserts voice_stop[v]; busy[v] clears at ISSUE's closing edge.
  - No match: no pulse; event silently consumed.
- voice_done[i] clears busy[i] at next edge. voice_key is unchanged.
- Age: sample tick = sample_clk rising edge, detected via a one-flop history register (reset 0). Each busy voice's age increments per tick, saturating at 2^AGE_W-1. Non-busy ages hold.
- Simultaneous events:
  - voice_done[v] in the ISSUE cycle that starts v: start wins, busy stays 1.
  - voice_done in the SEARCH cycle is not visible to that search.
  - A tick in the ISSUE cycle on the started voice: reset-to-0 wins.
- Reset (any time, including mid-ISSUE):
  - state = IDLE.
  - voice_busy, voice_key, ages, sample_clk history all 0.
  - All outputs 0 immediately, without waiting for a clock edge.
  - key_ready = 0; active_count = 0.

## Timing
- Event accepted at edge t: SEARCH occupies cycle t..t+1; ISSUE cycle t+1..t+2 drives voice_start/voice_stop/steal.
- voice_busy/voice_key update at edge t+2; key_ready high again from t+2.
- Throughput: one event per 3 Clk cycles.
- All outputs are decoded from state and registered selection only. No combinational path from key_valid/key_code to any output.
- voice_done to busy clear: 1 cycle.
- active_count is combinational from voice_busy.

## Structure
- Package voice_sched_pkg holds:
  - state enum (logic [1:0]: IDLE, READY, SEARCH, ISSUE)
  - default KEY_W/AGE_W localparams
  - pick-result struct {voice index, found, steal}
- Sub-module voice_pick: combinational, parameterized by NUM_VOICES/KEY_W/AGE_W.
  - Inputs: busy, keys, ages, key_code, key_on.
  - Output: pick-result.
  - Contains match, first-free and oldest-argmax priority logic.
- Top holds the FSM, latched event, age counters, busy/key registers and tick detector.

## Test plan
- Reset_n low, then init = 1; four note-ons keys 60, 62, 64, 65 -> voice_start = 0001, 0010, 0100, 1000; each pulse 2 cycles after acceptance; active_count = 4; steal = 0.
- All 4 busy; ages 10, 30, 30, 5 ticks; note-on key 70 -> voice_start = 0010, steal = 1, voice_key[1] = 70, age[1] = 0.
- Voice 2 holds key 64; note-on 64 -> voice_start = 0100, steal = 0, busy unchanged. Then note-off 64 -> voice_stop = 0100, busy[2] = 0. Then note-off 99 -> no pulses, key_ready back after 2 cycles.
- voice_done[0] pulsed in the same cycle ISSUE starts voice 0 -> busy[0] stays 1. voice_done[3] alone -> busy[3] = 0 next cycle, active_count decrements.
- Reset_n asserted during ISSUE -> voice_start drops without a clock edge; all busy 0; key_ready stays 0 until init = 1.
- Age saturation with AGE_W = 2: 5 ticks on a busy voice -> age = 3. Idle voice age stays 0.

Source files
------------

// File: rtl/voice_sched_pkg.sv
// Shared types and defaults for the voice scheduler: FSM state, default widths,
// and the registered voice-pick result.
package voice_sched_pkg;

  localparam int unsigned DefKeyW   = 7;
  localparam int unsigned DefAgeW   = 8;
  // Wide enough for the largest supported bank of 16 voices.
  localparam int unsigned VoiceIdxW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StReady,
    StSearch,
    StIssue
  } state_e;

  typedef struct packed {
    logic [VoiceIdxW-1:0] voice;
    logic                 found;
    logic                 steal;
  } pick_t;

endpackage

// File: rtl/voice_pick.sv
// Combinational voice selection: retrigger match first, then lowest free voice,
// then the oldest busy voice as a steal victim (note-on only).
module voice_pick
  import voice_sched_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned KEY_W      = DefKeyW,
  parameter int unsigned AGE_W      = DefAgeW
) (
  input  logic [NUM_VOICES-1:0]       busy,
  input  logic [NUM_VOICES*KEY_W-1:0] keys,
  input  logic [NUM_VOICES*AGE_W-1:0] ages,
  input  logic [KEY_W-1:0]            key_code,
  input  logic                        key_on,
  output pick_t                       pick
);

  logic                 match_found;
  logic [VoiceIdxW-1:0] match_idx;
  logic                 free_found;
  logic [VoiceIdxW-1:0] free_idx;
  logic                 old_found;
  logic [VoiceIdxW-1:0] old_idx;
  logic [AGE_W-1:0]     old_age;

  // Descending scans so the lowest index is the last to win.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (busy[i] && (keys[i*KEY_W +: KEY_W] == key_code)) begin
        match_found = 1'b1;
        match_idx   = VoiceIdxW'(i);
      end
      if (!busy[i]) begin
        free_found = 1'b1;
        free_idx   = VoiceIdxW'(i);
      end
    end
  end

  // Strictly-greater compare keeps the lowest index on age ties.
  always_comb begin
    old_found = 1'b0;
    old_idx   = '0;
    old_age   = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (busy[i] && (!old_found || (ages[i*AGE_W +: AGE_W] > old_age))) begin
        old_found = 1'b1;
        old_idx   = VoiceIdxW'(i);
        old_age   = ages[i*AGE_W +: AGE_W];
      end
    end
  end

  always_comb begin
    pick = '0;
    if (match_found) begin
      pick.voice = match_idx;
      pick.found = 1'b1;
    end else if (key_on && free_found) begin
      pick.voice = free_idx;
      pick.found = 1'b1;
    end else if (key_on && old_found) begin
      pick.voice = old_idx;
      pick.found = 1'b1;
      pick.steal = 1'b1;
    end
  end

endmodule

// File: rtl/voice_scheduler.sv
// Allocates note-on/note-off key events to a bank of playback voices, issuing
// one-cycle start/stop pulses and tracking per-voice ownership, key and age.
module voice_scheduler
  import voice_sched_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned KEY_W      = DefKeyW,
  parameter int unsigned AGE_W      = DefAgeW
) (
  input  logic                             Clk,
  input  logic                             Reset_n,
  input  logic                             init,
  input  logic                             sample_clk,
  input  logic                             key_valid,
  output logic                             key_ready,
  input  logic                             key_on,
  input  logic [KEY_W-1:0]                 key_code,
  input  logic [NUM_VOICES-1:0]            voice_done,
  output logic [NUM_VOICES-1:0]            voice_start,
  output logic [NUM_VOICES-1:0]            voice_stop,
  output logic [NUM_VOICES*KEY_W-1:0]      voice_key,
  output logic [NUM_VOICES-1:0]            voice_busy,
  output logic                             steal,
  output logic [$clog2(NUM_VOICES):0]      active_count
);

  localparam int unsigned      CntW   = $clog2(NUM_VOICES) + 1;
  localparam logic [AGE_W-1:0] AgeMax = '1;

  state_e                      state_q, state_d;
  logic                        ev_on_q;
  logic [KEY_W-1:0]            ev_code_q;
  pick_t                       pick_q, pick_w;
  logic [NUM_VOICES-1:0]       busy_q, busy_d;
  logic [NUM_VOICES*KEY_W-1:0] key_q, key_d;
  logic [AGE_W-1:0]            age_q [NUM_VOICES];
  logic [AGE_W-1:0]            age_d [NUM_VOICES];
  logic [NUM_VOICES*AGE_W-1:0] ages_flat;
  logic                        sc_hist_q;
  logic                        tick;
  logic                        issue;
  logic [NUM_VOICES-1:0]       sel_oh;

  voice_pick #(
    .NUM_VOICES(NUM_VOICES),
    .KEY_W     (KEY_W),
    .AGE_W     (AGE_W)
  ) u_pick (
    .busy    (busy_q),
    .keys    (key_q),
    .ages    (ages_flat),
    .key_code(ev_code_q),
    .key_on  (ev_on_q),
    .pick    (pick_w)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (init) state_d = StReady;
      StReady:  if (key_valid) state_d = StSearch;
      StSearch: state_d = StIssue;
      StIssue:  state_d = StReady;
      default:  state_d = StIdle;
    endcase
  end

  assign issue = (state_q == StIssue);

  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      sel_oh[i] = pick_q.found && (pick_q.voice == VoiceIdxW'(i));
    end
  end

  // Outputs depend only on state and the registered event/selection.
  always_comb begin
    key_ready   = (state_q == StReady);
    voice_start = (issue && ev_on_q)  ? sel_oh : '0;
    voice_stop  = (issue && !ev_on_q) ? sel_oh : '0;
    steal       = issue && ev_on_q && pick_q.steal;
  end

  assign tick = sample_clk & ~sc_hist_q;

  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      ages_flat[i*AGE_W +: AGE_W] = age_q[i];
    end
  end

  // Issue actions are applied last so a start overrides a same-cycle done or tick.
  always_comb begin
    busy_d = busy_q & ~voice_done;
    key_d  = key_q;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (busy_q[i] && tick && (age_q[i] != AgeMax)) age_d[i] = age_q[i] + 1'b1;
      else                                          age_d[i] = age_q[i];
    end
    if (issue) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (sel_oh[i]) begin
          if (ev_on_q) begin
            busy_d[i]                = 1'b1;
            key_d[i*KEY_W +: KEY_W] = ev_code_q;
            age_d[i]                 = '0;
          end else begin
            busy_d[i] = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ev_on_q   <= 1'b0;
      ev_code_q <= '0;
      pick_q    <= '0;
      busy_q    <= '0;
      key_q     <= '0;
      sc_hist_q <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) age_q[i] <= '0;
    end else begin
      if ((state_q == StReady) && key_valid) begin
        ev_on_q   <= key_on;
        ev_code_q <= key_code;
      end
      if (state_q == StSearch) pick_q <= pick_w;
      busy_q    <= busy_d;
      key_q     <= key_d;
      sc_hist_q <= sample_clk;
      for (int i = 0; i < NUM_VOICES; i++) age_q[i] <= age_d[i];
    end
  end

  assign voice_busy = busy_q;
  assign voice_key  = key_q;

  always_comb begin
    active_count = '0;
    for (int i = 0; i < NUM_VOICES; i++) active_count = active_count + CntW'(busy_q[i]);
  end

endmodule

// File: tb/tb_voice_scheduler.sv
// Self-checking bench for voice_scheduler: directed scenarios plus random events,
// compared every cycle against a behavioural allocation model.
module tb_voice_scheduler;

  localparam int unsigned NV = 4;
  localparam int unsigned KW = 7;
  localparam int unsigned AW = 8;
  localparam int AGE_SAT = (1 << AW) - 1;

  logic          Clk = 1'b0;
  logic          Reset_n, init, sample_clk, key_valid, key_on;
  logic [KW-1:0] key_code;
  logic [NV-1:0] voice_done;
  logic          key_ready, steal;
  logic [NV-1:0] voice_start, voice_stop, voice_busy;
  logic [NV*KW-1:0] voice_key;
  logic [2:0]    active_count;
  logic          key_ready2, steal2;
  logic [NV-1:0] voice_start2, voice_stop2, voice_busy2;
  logic [NV*KW-1:0] voice_key2;
  logic [2:0]    active_count2;

  always #5 Clk = ~Clk;

  voice_scheduler #(.NUM_VOICES(NV), .KEY_W(KW), .AGE_W(AW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .init(init), .sample_clk(sample_clk),
    .key_valid(key_valid), .key_ready(key_ready), .key_on(key_on), .key_code(key_code),
    .voice_done(voice_done), .voice_start(voice_start), .voice_stop(voice_stop),
    .voice_key(voice_key), .voice_busy(voice_busy), .steal(steal),
    .active_count(active_count)
  );

  // Narrow-age instance sharing all inputs, used only for the saturation scenario.
  voice_scheduler #(.NUM_VOICES(NV), .KEY_W(KW), .AGE_W(2)) dut2 (
    .Clk(Clk), .Reset_n(Reset_n), .init(init), .sample_clk(sample_clk),
    .key_valid(key_valid), .key_ready(key_ready2), .key_on(key_on), .key_code(key_code),
    .voice_done(voice_done), .voice_start(voice_start2), .voice_stop(voice_stop2),
    .voice_key(voice_key2), .voice_busy(voice_busy2), .steal(steal2),
    .active_count(active_count2)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  bit rnd    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: m_phase counts cycles remaining until the event completes.
  logic [NV-1:0] m_busy;
  logic [KW-1:0] m_key [NV];
  int            m_age [NV];
  logic          m_sc, m_init, m_on, m_found;
  logic [KW-1:0] m_code;
  int            m_phase, m_tgt;
  logic [NV-1:0] e_start, e_stop;
  logic          e_steal;

  function automatic void model_pick(input logic on, input logic [KW-1:0] code,
                                     output int v, output bit f, output bit s);
    int best;
    v = 0; f = 1'b0; s = 1'b0;
    for (int i = 0; i < NV; i++)
      if (m_busy[i] && m_key[i] == code) begin v = i; f = 1'b1; return; end
    if (!on) return;
    for (int i = 0; i < NV; i++)
      if (!m_busy[i]) begin v = i; f = 1'b1; return; end
    best = -1;
    for (int i = 0; i < NV; i++)
      if (m_age[i] > best) begin best = m_age[i]; v = i; end
    f = 1'b1;
    s = 1'b1;
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_busy <= '0; m_sc <= 1'b0; m_init <= 1'b0; m_on <= 1'b0; m_found <= 1'b0;
      m_code <= '0; m_phase <= 0; m_tgt <= 0;
      e_start <= '0; e_stop <= '0; e_steal <= 1'b0;
      for (int i = 0; i < NV; i++) begin m_key[i] <= '0; m_age[i] <= 0; end
    end else begin : upd
      automatic logic [NV-1:0] nb = m_busy & ~voice_done;
      automatic logic tk = sample_clk && !m_sc;
      automatic int v;
      automatic bit f, s;
      m_sc <= sample_clk;
      if (init) m_init <= 1'b1;
      e_start <= '0; e_stop <= '0; e_steal <= 1'b0;
      for (int i = 0; i < NV; i++)
        if (m_busy[i] && tk && m_age[i] < AGE_SAT) m_age[i] <= m_age[i] + 1;
      case (m_phase)
        0: if (m_init && key_valid) begin
             m_on <= key_on; m_code <= key_code; m_phase <= 2;
           end
        2: begin
             model_pick(m_on, m_code, v, f, s);
             m_tgt <= v; m_found <= f; m_phase <= 1;
             if (f && m_on)  e_start <= NV'(1 << v);
             if (f && !m_on) e_stop  <= NV'(1 << v);
             e_steal <= s;
           end
        default: begin
             if (m_found && m_on) begin
               nb[m_tgt] = 1'b1; m_key[m_tgt] <= m_code; m_age[m_tgt] <= 0;
             end else if (m_found) begin
               nb[m_tgt] = 1'b0;
             end
             m_phase <= 0;
           end
      endcase
      m_busy <= nb;
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin : cmp
      automatic logic [NV*KW-1:0] ek;
      for (int i = 0; i < NV; i++) ek[i*KW +: KW] = m_key[i];
      chk("key_ready", key_ready, m_init && m_phase == 0);
      chk("voice_start", voice_start, e_start);
      chk("voice_stop", voice_stop, e_stop);
      chk("steal", steal, e_steal);
      chk("voice_busy", voice_busy, m_busy);
      chk("voice_key", voice_key, ek);
      chk("active_count", active_count, $countones(m_busy));
    end
  end

  task automatic step();
    @(negedge Clk);
    voice_done = '0;
    if (rnd) begin
      sample_clk = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) voice_done = NV'($urandom_range(0, 15));
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      step(); sample_clk = 1'b1;
      step(); sample_clk = 1'b0;
    end
  endtask

  // Returns at the negedge inside the ISSUE cycle with that cycle's pulses captured.
  task automatic send(input logic on, input logic [KW-1:0] code, input logic [NV-1:0] done_issue,
                      output logic [NV-1:0] st, output logic [NV-1:0] sp, output logic sl);
    int guard = 0;
    step();
    while (!key_ready && guard < 20) begin step(); guard++; end
    chk("key_ready_wait", key_ready, 1);
    key_valid = 1'b1; key_on = on; key_code = code;
    step();
    key_valid = 1'b0;
    step();
    st = voice_start; sp = voice_stop; sl = steal;
    voice_done = voice_done | done_issue;
  endtask

  logic [NV-1:0] st, sp;
  logic          sl;

  initial begin
    Reset_n = 1'b0; init = 1'b0; sample_clk = 1'b0; key_valid = 1'b0;
    key_on = 1'b0; key_code = '0; voice_done = '0;
    repeat (3) step();
    chk_en = 1'b1;
    chk("rst_ready", key_ready, 0);
    chk("rst_count", active_count, 0);
    Reset_n = 1'b1;
    step();
    init = 1'b1;

    // Fill all four voices.
    send(1'b1, 7'd60, '0, st, sp, sl); chk("on60_start", st, 4'b0001); chk("on60_steal", sl, 0);
    send(1'b1, 7'd62, '0, st, sp, sl); chk("on62_start", st, 4'b0010);
    send(1'b1, 7'd64, '0, st, sp, sl); chk("on64_start", st, 4'b0100);
    send(1'b1, 7'd65, '0, st, sp, sl); chk("on65_start", st, 4'b1000); chk("on65_steal", sl, 0);
    step();
    chk("full_count", active_count, 4);

    // Ages become 10, 30, 30, 5: steal must pick voice 1.
    tick(20);
    send(1'b1, 7'd60, '0, st, sp, sl); chk("retrig60", st, 4'b0001);
    tick(5);
    send(1'b1, 7'd65, '0, st, sp, sl); chk("retrig65", st, 4'b1000);
    tick(5);
    send(1'b1, 7'd70, '0, st, sp, sl); chk("steal_start", st, 4'b0010); chk("steal_flag", sl, 1);
    step();
    chk("steal_key", voice_key[1*KW +: KW], 70);
    chk("steal_age", dut.age_q[1], 0);

    send(1'b1, 7'd64, '0, st, sp, sl); chk("retrig64", st, 4'b0100); chk("retrig64_steal", sl, 0);
    step();
    chk("retrig_busy", voice_busy, 4'b1111);
    send(1'b0, 7'd64, '0, st, sp, sl); chk("off64_stop", sp, 4'b0100);
    step();
    chk("off64_busy", voice_busy[2], 0);
    send(1'b0, 7'd99, '0, st, sp, sl); chk("off99_start", st, 0); chk("off99_stop", sp, 0);
    step();
    chk("off99_ready", key_ready, 1);

    // Done coinciding with a start on the same voice.
    send(1'b1, 7'd60, 4'b0001, st, sp, sl); chk("done_clash_start", st, 4'b0001);
    step();
    chk("done_clash_busy", voice_busy[0], 1);
    chk("pre_done_count", active_count, 3);
    voice_done = 4'b1000;
    step();
    chk("done3_busy", voice_busy[3], 0);
    chk("done3_count", active_count, 2);

    // Reset during ISSUE clears outputs without a clock edge.
    send(1'b1, 7'd66, '0, st, sp, sl); chk("pre_rst_start", st, 4'b0100);
    #1 Reset_n = 1'b0; init = 1'b0;
    #1;
    chk("async_start", voice_start, 0);
    chk("async_busy", voice_busy, 0);
    chk("async_ready", key_ready, 0);
    chk("async_count", active_count, 0);
    step();
    Reset_n = 1'b1;
    repeat (3) step();
    chk("no_init_ready", key_ready, 0);
    init = 1'b1;
    step(); step();
    chk("init_ready", key_ready, 1);

    // Saturation on the narrow-age instance: v0 saturates at 3 instead of wrapping.
    send(1'b1, 7'd10, '0, st, sp, sl); chk("sat_v0_start", voice_start2, 4'b0001);
    tick(5);
    chk("sat_age0", dut2.age_q[0], 3);
    chk("sat_age1_idle", dut2.age_q[1], 0);
    send(1'b1, 7'd11, '0, st, sp, sl);
    send(1'b1, 7'd12, '0, st, sp, sl);
    send(1'b1, 7'd13, '0, st, sp, sl);
    tick(3);
    send(1'b1, 7'd14, '0, st, sp, sl);
    chk("sat_steal_start", voice_start2, 4'b0001);
    chk("sat_steal_flag", steal2, 1);

    // Random traffic against the model.
    rnd = 1'b1;
    repeat (300) begin
      send(1'($urandom_range(0, 9) < 7), KW'(60 + $urandom_range(0, 7)), '0, st, sp, sl);
    end
    rnd = 1'b0;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
